// File: rtl/pb_front_if.sv
// rtl/pb_front_if.sv - pushbutton pads in, debounced levels and arbitrated events out
interface pb_front_if;
    logic pbl_raw;
    logic pbr_raw;
    logic pbl_db;
    logic pbr_db;
    logic pl_press;
    logic pr_press;
    logic tie_press;
    logic pl_hold;
    logic pr_hold;

    modport master (
        output pbl_raw, pbr_raw,
        input  pbl_db, pbr_db, pl_press, pr_press, tie_press, pl_hold, pr_hold
    );

    modport slave (
        input  pbl_raw, pbr_raw,
        output pbl_db, pbr_db, pl_press, pr_press, tie_press, pl_hold, pr_hold
    );
endinterface

// File: rtl/pb_front.sv
// rtl/pb_front.sv - tug-of-war pushbutton sync, debounce, press arbitration and hold detect
module pb_front #(
    parameter int DB_CYCLES   = 10,
    parameter int TIE_WIN     = 2,
    parameter int HOLD_CYCLES = 500
) (
    input logic       clk,
    input logic       rst,
    pb_front_if.slave pb
);
    localparam int DBW = $clog2(DB_CYCLES);
    localparam int TW  = $clog2(TIE_WIN + 1);
    localparam int HW  = $clog2(HOLD_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
    localparam logic [TW-1:0]  TIE_LAST = TW'(TIE_WIN - 1);
    localparam logic [HW-1:0]  HOLD_MAX = HW'(HOLD_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT_L, WAIT_R} state_t;

    // bit 0 = left button, bit 1 = right button
    logic [1:0]     raw, s1, s, db, db_q, rise, hold;
    logic [DBW-1:0] db_cnt   [2];
    logic [HW-1:0]  hold_cnt [2];

    state_t         state, state_nxt;
    logic [TW-1:0]  timer, timer_nxt;
    logic           pl_q, pr_q, tie_q;
    logic           pl_nxt, pr_nxt, tie_nxt;

    assign raw  = {pb.pbr_raw, pb.pbl_raw};
    assign rise = db & ~db_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1   <= '0;
            s    <= '0;
            db_q <= '0;
        end else begin
            s1   <= raw;
            s    <= s1;
            db_q <= db;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db   <= '0;
            hold <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i]   <= '0;
                hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                // db flips only after DB_CYCLES consecutive disagreeing samples
                if (s[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= ~db[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end

                if (!db[i]) begin
                    hold_cnt[i] <= '0;
                end else if (hold_cnt[i] != HOLD_MAX) begin
                    hold_cnt[i] <= hold_cnt[i] + 1'b1;
                end
                // gated by db so the flag drops on the edge right after release
                hold[i] <= db[i] & (hold_cnt[i] == HOLD_MAX);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            timer <= '0;
            pl_q  <= 1'b0;
            pr_q  <= 1'b0;
            tie_q <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            pl_q  <= pl_nxt;
            pr_q  <= pr_nxt;
            tie_q <= tie_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rise[0] && !rise[1])      state_nxt = WAIT_L;
                else if (rise[1] && !rise[0]) state_nxt = WAIT_R;
            end
            WAIT_L: if (rise[1] || timer == TIE_LAST) state_nxt = IDLE;
            WAIT_R: if (rise[0] || timer == TIE_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        timer_nxt = timer;
        pl_nxt    = 1'b0;
        pr_nxt    = 1'b0;
        tie_nxt   = 1'b0;
        case (state)
            IDLE: begin
                timer_nxt = '0;
                tie_nxt   = rise[0] & rise[1];
            end
            WAIT_L: begin
                if (rise[1])                tie_nxt   = 1'b1;
                else if (timer == TIE_LAST) pl_nxt    = 1'b1;
                else                        timer_nxt = timer + 1'b1;
            end
            WAIT_R: begin
                if (rise[0])                tie_nxt   = 1'b1;
                else if (timer == TIE_LAST) pr_nxt    = 1'b1;
                else                        timer_nxt = timer + 1'b1;
            end
            default: timer_nxt = '0;
        endcase
    end

    assign pb.pbl_db    = db[0];
    assign pb.pbr_db    = db[1];
    assign pb.pl_press  = pl_q;
    assign pb.pr_press  = pr_q;
    assign pb.tie_press = tie_q;
    assign pb.pl_hold   = hold[0];
    assign pb.pr_hold   = hold[1];
endmodule

// File: tb/tb_pb_front.sv
// tb/tb_pb_front.sv - vector table, corner sequences and random run against a window-based model
module tb_pb_front;
    localparam int DB   = 10;
    localparam int TW   = 2;
    localparam int HC   = 500;
    localparam int MAXN = 16384;

    logic clk = 1'b0;
    logic rst = 1'b0;

    pb_front_if pb ();

    pb_front #(.DB_CYCLES(DB), .TIE_WIN(TW), .HOLD_CYCLES(HC)) dut (
        .clk (clk),
        .rst (rst),
        .pb  (pb)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model history, indexed by absolute edge number
    bit raw_h [2][MAXN];
    bit db_h  [2][MAXN];
    int n = 0;
    int base = 0;
    int pend = 0;
    int pstart = 0;
    bit e_pl, e_pr, e_tie, e_hl, e_hr;

    // per-sequence event records, edge index k relative to sequence start
    int k;
    int f_ldb_rise, f_ldb_fall, f_rdb_rise, f_hl_rise, f_hl_fall;
    int f_pl, f_pr, f_tie, n_pl, n_pr, n_tie;
    logic [6:0] prev;

    typedef struct {
        string name;
        int    l_at;
        int    r_at;
        int    len;
        int    e_ldb;
        int    e_pl;
        int    e_pr;
        int    e_tie;
        int    c_pl;
        int    c_pr;
        int    c_tie;
    } vec_t;

    vec_t vt [6];

    function automatic bit get_raw(int side, int m);
        if (m <= base) return 1'b0;
        return raw_h[side][m];
    endfunction

    function automatic bit get_db(int side, int m);
        if (m <= base) return 1'b0;
        return db_h[side][m];
    endfunction

    task automatic chk_vec(string name, logic [6:0] got, logic [6:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s edge %0d got %b want %b", name, n, got, want);
        end
    endtask

    task automatic chk_int(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic model_edge(bit l, bit r, bit rst_v);
        bit dbp, tog, rl, rr;
        n++;
        raw_h[0][n] = l;
        raw_h[1][n] = r;
        e_pl = 0; e_pr = 0; e_tie = 0; e_hl = 0; e_hr = 0;
        if (!rst_v) begin
            base = n;
            pend = 0;
            return;
        end
        // a level changes once the last DB synchronised samples all disagree with it
        for (int side = 0; side < 2; side++) begin
            dbp = get_db(side, n - 1);
            tog = 1'b1;
            for (int m = n - DB + 1; m <= n; m++)
                if (get_raw(side, m - 2) == dbp) tog = 1'b0;
            db_h[side][n] = tog ? ~dbp : dbp;
        end
        rl = get_db(0, n - 1) & ~get_db(0, n - 2);
        rr = get_db(1, n - 1) & ~get_db(1, n - 2);
        if (pend == 0) begin
            if (rl && rr) e_tie = 1;
            else if (rl) begin pend = 1; pstart = n; end
            else if (rr) begin pend = 2; pstart = n; end
        end else if (pend == 1) begin
            if (rr) begin e_tie = 1; pend = 0; end
            else if (n == pstart + TW) begin e_pl = 1; pend = 0; end
        end else begin
            if (rl) begin e_tie = 1; pend = 0; end
            else if (n == pstart + TW) begin e_pr = 1; pend = 0; end
        end
        e_hl = 1; e_hr = 1;
        for (int m = n - 1 - HC; m <= n - 1; m++) begin
            if (!get_db(0, m)) e_hl = 0;
            if (!get_db(1, m)) e_hr = 0;
        end
    endtask

    task automatic clear_rec();
        k = 0;
        f_ldb_rise = -1; f_ldb_fall = -1; f_rdb_rise = -1;
        f_hl_rise = -1;  f_hl_fall = -1;
        f_pl = -1; f_pr = -1; f_tie = -1;
        n_pl = 0;  n_pr = 0;  n_tie = 0;
        prev = '0;
    endtask

    task automatic cyc(bit l, bit r);
        logic [6:0] act;
        pb.pbl_raw = l;
        pb.pbr_raw = r;
        @(posedge clk);
        model_edge(l, r, rst);
        #1;
        act = {pb.pbl_db, pb.pbr_db, pb.pl_press, pb.pr_press, pb.tie_press, pb.pl_hold, pb.pr_hold};
        chk_vec("model", act, {get_db(0, n), get_db(1, n), e_pl, e_pr, e_tie, e_hl, e_hr});
        if (act[6] && !prev[6] && f_ldb_rise < 0) f_ldb_rise = k;
        if (!act[6] && prev[6] && f_ldb_fall < 0) f_ldb_fall = k;
        if (act[5] && f_rdb_rise < 0) f_rdb_rise = k;
        if (act[1] && !prev[1] && f_hl_rise < 0) f_hl_rise = k;
        if (!act[1] && prev[1] && f_hl_fall < 0) f_hl_fall = k;
        if (act[4]) begin n_pl++;  if (f_pl < 0)  f_pl = k;  end
        if (act[3]) begin n_pr++;  if (f_pr < 0)  f_pr = k;  end
        if (act[2]) begin n_tie++; if (f_tie < 0) f_tie = k; end
        prev = act;
        k++;
    endtask

    task automatic pull_reset(string name);
        logic [6:0] act;
        rst = 1'b0;
        #1;
        act = {pb.pbl_db, pb.pbr_db, pb.pl_press, pb.pr_press, pb.tie_press, pb.pl_hold, pb.pr_hold};
        chk_vec(name, act, 7'b0);
    endtask

    task automatic fresh_start();
        pull_reset("reset_outputs");
        cyc(0, 0);
        cyc(0, 0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cyc(0, 0);
        clear_rec();
    endtask

    initial begin
        bit l, r;
        pb.pbl_raw = 1'b0;
        pb.pbr_raw = 1'b0;

        vt[0] = '{"single_l", 0, -1, 40, 11, 14, -1, -1, 1, 0, 0};
        vt[1] = '{"single_r", -1, 0, 40, -1, -1, 14, -1, 0, 1, 0};
        vt[2] = '{"tie_e1",   0,  1, 40, 11, -1, -1, 13, 0, 0, 1};
        vt[3] = '{"tie_e2",   0,  2, 40, 11, -1, -1, 14, 0, 0, 1};
        vt[4] = '{"late_e3",  0,  3, 40, 11, 14, 17, -1, 1, 1, 0};
        vt[5] = '{"same_cyc", 0,  0, 40, 11, -1, -1, 12, 0, 0, 1};

        cyc(0, 0);
        cyc(0, 0);
        rst = 1'b1;
        cyc(0, 0);

        for (int v = 0; v < 6; v++) begin
            fresh_start();
            for (int i = 0; i < vt[v].len; i++)
                cyc(vt[v].l_at >= 0 && i >= vt[v].l_at, vt[v].r_at >= 0 && i >= vt[v].r_at);
            chk_int({vt[v].name, "_ldb"},   f_ldb_rise, vt[v].e_ldb);
            chk_int({vt[v].name, "_pl"},    f_pl,       vt[v].e_pl);
            chk_int({vt[v].name, "_pr"},    f_pr,       vt[v].e_pr);
            chk_int({vt[v].name, "_tie"},   f_tie,      vt[v].e_tie);
            chk_int({vt[v].name, "_npl"},   n_pl,       vt[v].c_pl);
            chk_int({vt[v].name, "_npr"},   n_pr,       vt[v].c_pr);
            chk_int({vt[v].name, "_ntie"},  n_tie,      vt[v].c_tie);
        end

        fresh_start();
        for (int i = 0; i < 30; i++) cyc(0, ((i / 3) % 2) == 0);
        for (int i = 0; i < 10; i++) cyc(0, 0);
        chk_int("bounce_rdb", f_rdb_rise, -1);
        chk_int("bounce_events", n_pl + n_pr + n_tie, 0);
        clear_rec();
        for (int i = 0; i < 20; i++) cyc(0, 1);
        chk_int("bounce_then_npr", n_pr, 1);
        chk_int("bounce_then_pr", f_pr, 14);

        fresh_start();
        for (int i = 0; i < 520; i++) cyc(1, 0);
        for (int i = 0; i < 30; i++) cyc(0, 0);
        chk_int("hold_ldb_rise", f_ldb_rise, 11);
        chk_int("hold_rise_delay", f_hl_rise - f_ldb_rise, 501);
        chk_int("hold_ldb_fall", f_ldb_fall, 531);
        chk_int("hold_fall_after_db", f_hl_fall - f_ldb_fall, 1);
        chk_int("hold_npl", n_pl, 1);

        fresh_start();
        for (int i = 0; i < 13; i++) cyc(1, 0);
        chk_int("mid_no_pl_yet", n_pl, 0);
        pull_reset("mid_reset_outputs");
        cyc(1, 0);
        cyc(1, 0);
        rst = 1'b1;
        clear_rec();
        for (int i = 0; i < 30; i++) cyc(1, 0);
        chk_int("post_reset_pl", f_pl, 14);
        chk_int("post_reset_npl", n_pl, 1);

        fresh_start();
        l = 0;
        r = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) l = ~l;
            if ($urandom_range(0, 11) == 0) r = ~r;
            if (i == 700) begin
                pull_reset("rand_reset_outputs");
                cyc(l, r);
                rst = 1'b1;
            end
            cyc(l, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
